// File: rtl/apb_pkg.sv
// Shared APB definitions: command-master FSM encodings and default bus widths
// reusable by APB slaves.
package apb_pkg;

  localparam int unsigned ApbAddrWidth = 16;
  localparam int unsigned ApbDataWidth = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_master_timer.sv
// ACCESS-phase wait counter for apb_cmd_master; only built with
// APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(Limit + 1);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CntWidth'(Limit))) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  // Fires in the wait cycle whose increment would take the count to Limit.
  assign expired = enable && (cnt_q == CntWidth'(Limit - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB3 initiator, one transfer in flight.
// Optional ACCESS timeout enabled by defining APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned W_ADDR         = ApbAddrWidth,
  parameter int unsigned W_DATA         = ApbDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic [W_DATA-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              timeout,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [W_ADDR-1:0] apbm_paddr,
  output logic [W_DATA-1:0] apbm_pwdata,
  input  logic [W_DATA-1:0] apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
);

  apb_state_e state_q;
  logic       expired;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  logic tmr_expired;

  apb_cmd_master_timer #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == StSetup),
    .enable ((state_q == StAccess) && !apbm_pready),
    .expired(tmr_expired)
  );

  assign expired = tmr_expired;
`else
  // No timer: ACCESS waits indefinitely; the term only keeps the parameter referenced.
  assign expired = 1'b0 & (TIMEOUT_CYCLES == 32'hFFFF_FFFF);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      timeout      <= 1'b0;
      apbm_psel    <= 1'b0;
      apbm_penable <= 1'b0;
      apbm_pwrite  <= 1'b0;
      apbm_paddr   <= '0;
      apbm_pwdata  <= '0;
    end else begin
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready   <= 1'b0;
            apbm_psel   <= 1'b1;
            apbm_pwrite <= cmd_write;
            apbm_paddr  <= cmd_addr;
            apbm_pwdata <= cmd_wdata;
            state_q     <= StSetup;
          end else begin
            // Also raises cmd_ready on the first cycle out of reset.
            cmd_ready <= 1'b1;
          end
        end
        StSetup: begin
          apbm_penable <= 1'b1;
          state_q      <= StAccess;
        end
        StAccess: begin
          if (apbm_pready) begin
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= apbm_pwrite ? '0 : apbm_prdata;
            rsp_err      <= apbm_pslverr;
            state_q      <= StResp;
          end else if (expired) begin
            apbm_psel    <= 1'b0;
            apbm_penable <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b1;
            timeout      <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a wait-state programmable APB slave.
// Exercises the timeout path when APB_CMD_MASTER_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timeout;
  logic        apbm_psel, apbm_penable, apbm_pwrite;
  logic [15:0] apbm_paddr;
  logic [31:0] apbm_pwdata;
  logic [31:0] apbm_prdata;
  logic        apbm_pready;
  logic        apbm_pslverr;

  int checks = 0;
  int errors = 0;

  int          wait_n = 0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err = 1'b0;
  int          wcnt = 0;

  apb_cmd_master #(
    .W_ADDR        (16),
    .W_DATA        (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .timeout     (timeout),
    .apbm_psel   (apbm_psel),
    .apbm_penable(apbm_penable),
    .apbm_pwrite (apbm_pwrite),
    .apbm_paddr  (apbm_paddr),
    .apbm_pwdata (apbm_pwdata),
    .apbm_prdata (apbm_prdata),
    .apbm_pready (apbm_pready),
    .apbm_pslverr(apbm_pslverr)
  );

  always #5 clk = ~clk;

  // Slave: holds pready low for wait_n ACCESS cycles, then completes.
  always_ff @(posedge clk) begin
    if (apbm_psel && apbm_penable && !apbm_pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign apbm_pready  = apbm_psel && apbm_penable && (wcnt >= wait_n);
  assign apbm_prdata  = slv_rdata;
  assign apbm_pslverr = slv_err;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one command (cmd_ready must be 1) and returns at the first rsp_valid cycle.
  // lat counts cycles after the accept edge: 1 = SETUP cycle.
  task automatic run_xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                          output int lat, output int psel_n, output int pen_n,
                          output bit stable, output bit to_seen);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
    lat = 1; psel_n = 0; pen_n = 0; stable = 1'b1; to_seen = 1'b0;
    while (!rsp_valid && lat < 300) begin
      if (apbm_psel) psel_n++;
      if (apbm_penable) pen_n++;
      if (apbm_psel && (apbm_paddr !== a || apbm_pwdata !== d || apbm_pwrite !== wr))
        stable = 1'b0;
      if (timeout) to_seen = 1'b1;
      tick();
      lat++;
    end
    if (timeout) to_seen = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({apbm_psel, apbm_penable, rsp_valid, cmd_ready, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {apbm_psel, apbm_penable, rsp_valid, cmd_ready, timeout});
    end
    checks++;
    if ({rsp_rdata, rsp_err, apbm_paddr} !== 49'h0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h err=%b paddr=%h want 0", rsp_rdata, rsp_err,
               apbm_paddr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_read_zero_wait;
    int lat, ps, pe;
    bit st, to;
    wait_n = 0; slv_rdata = 32'hA5A5_0001; slv_err = 1'b0; rsp_ready = 1'b1;
    run_xfer(1'b0, 16'h0004, 32'h0, lat, ps, pe, st, to);
    checks++;
    if (lat != 3 || ps != 2 || pe != 1 || !st) begin
      errors++;
      $display("FAIL read0_timing: got lat=%0d psel=%0d pen=%0d stable=%0d want 3 2 1 1",
               lat, ps, pe, st);
    end
    checks++;
    if (rsp_rdata !== 32'hA5A5_0001 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL read0_rsp: got rdata=%h err=%b want a5a50001 0", rsp_rdata, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || apbm_paddr !== 16'h0004) begin
      errors++;
      $display("FAIL read0_done: got valid=%b ready=%b paddr=%h want 0 1 0004",
               rsp_valid, cmd_ready, apbm_paddr);
    end
  endtask

  task automatic test_write_wait3;
    int lat, ps, pe;
    bit st, to;
    wait_n = 3; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0; rsp_ready = 1'b1;
    run_xfer(1'b1, 16'h0000, 32'h0000_00FF, lat, ps, pe, st, to);
    checks++;
    if (lat != 6 || ps != 5 || pe != 4 || !st) begin
      errors++;
      $display("FAIL write3_timing: got lat=%0d psel=%0d pen=%0d stable=%0d want 6 5 4 1",
               lat, ps, pe, st);
    end
    checks++;
    if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL write3_rsp: got rdata=%h err=%b to=%b want 0 0 0", rsp_rdata, rsp_err,
               timeout);
    end
    tick();
  endtask

  task automatic test_slave_error;
    int lat, ps, pe;
    bit st, to;
    wait_n = 0; slv_rdata = 32'h0000_0BAD; slv_err = 1'b1; rsp_ready = 1'b0;
    run_xfer(1'b0, 16'h0008, 32'h0, lat, ps, pe, st, to);
    checks++;
    if (lat != 3 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0000_0BAD) begin
      errors++;
      $display("FAIL slverr_rsp: got lat=%0d err=%b rdata=%h want 3 1 00000bad", lat, rsp_err,
               rsp_rdata);
    end
    slv_err = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
        errors++;
        $display("FAIL slverr_hold[%0d]: got ready=%b valid=%b err=%b want 0 1 1", i,
                 cmd_ready, rsp_valid, rsp_err);
      end
    end
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL slverr_release: got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_pressure;
    int lat, ps, pe;
    bit st, to;
    wait_n = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b0; rsp_ready = 1'b0;
    run_xfer(1'b0, 16'h0010, 32'h0, lat, ps, pe, st, to);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_wdata = 32'h0000_CAFE;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 ||
          apbm_psel !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: got ready=%b valid=%b rdata=%h psel=%b want 0 1 12345678 0",
                 i, cmd_ready, rsp_valid, rsp_rdata, apbm_psel);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (apbm_psel !== 1'b1 || apbm_penable !== 1'b0 || apbm_paddr !== 16'h0020 ||
        apbm_pwrite !== 1'b1 || apbm_pwdata !== 32'h0000_CAFE) begin
      errors++;
      $display("FAIL bp_accept: got psel=%b pen=%b paddr=%h pwrite=%b pwdata=%h want 1 0 0020 1 0000cafe",
               apbm_psel, apbm_penable, apbm_paddr, apbm_pwrite, apbm_pwdata);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_access;
    wait_n = 255; slv_err = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0030;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (apbm_psel !== 1'b1 || apbm_penable !== 1'b1) begin
      errors++;
      $display("FAIL rmid_wait: got psel=%b pen=%b want 1 1", apbm_psel, apbm_penable);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({apbm_psel, apbm_penable, rsp_valid, cmd_ready} !== 4'b0) begin
      errors++;
      $display("FAIL rmid_reset: got %b want 0000", {apbm_psel, apbm_penable, rsp_valid,
               cmd_ready});
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_release: got ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
    repeat (3) tick();
    checks++;
    if (rsp_valid !== 1'b0 || apbm_psel !== 1'b0) begin
      errors++;
      $display("FAIL rmid_no_rsp: got valid=%b psel=%b want 0 0", rsp_valid, apbm_psel);
    end
  endtask

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int lat, ps, pe;
    bit st, to;
    wait_n = 255; slv_rdata = 32'h5555_AAAA; slv_err = 1'b0; rsp_ready = 1'b1;
    run_xfer(1'b0, 16'h0040, 32'h0, lat, ps, pe, st, to);
    checks++;
    if (lat != 6 || ps != 5 || pe != 4 || timeout !== 1'b1 || apbm_psel !== 1'b0) begin
      errors++;
      $display("FAIL tmo_abort: got lat=%0d psel_n=%0d pen_n=%0d to=%b psel=%b want 6 5 4 1 0",
               lat, ps, pe, timeout, apbm_psel);
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL tmo_rsp: got err=%b rdata=%h want 1 0", rsp_err, rsp_rdata);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL tmo_pulse: got to=%b ready=%b want 0 1", timeout, cmd_ready);
    end
    wait_n = 3;
    run_xfer(1'b0, 16'h0044, 32'h0, lat, ps, pe, st, to);
    checks++;
    if (lat != 6 || to || rsp_err !== 1'b0 || rsp_rdata !== 32'h5555_AAAA) begin
      errors++;
      $display("FAIL tmo_race: got lat=%0d to=%0d err=%b rdata=%h want 6 0 0 5555aaaa", lat,
               to, rsp_err, rsp_rdata);
    end
    tick();
  endtask
`else
  task automatic test_long_wait;
    int lat, ps, pe;
    bit st, to;
    wait_n = 8; slv_rdata = 32'h0BAD_F00D; slv_err = 1'b0; rsp_ready = 1'b1;
    run_xfer(1'b0, 16'h0040, 32'h0, lat, ps, pe, st, to);
    checks++;
    if (lat != 11 || to || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL long_wait: got lat=%0d to=%0d err=%b rdata=%h want 11 0 0 0badf00d", lat,
               to, rsp_err, rsp_rdata);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait3();
    test_slave_error();
    test_back_pressure();
    test_reset_mid_access();
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB initiator that turns a simple valid/ready command stream into APB3 transfers and returns each result on a valid/ready response stream. It is the requester side for APB register slaves such as the GPIO block, used by debug transports and test harnesses to reach the peripheral bus without a CPU. One transfer is in flight at a time. An optional timeout aborts transfers whose slave never asserts PREADY.

## Interface
Parameters:
- W_ADDR, 16: APB address width.
- W_DATA, 32: APB data width.
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles before abort. Only meaningful with APB_CMD_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  W_ADDR  transfer address.
- cmd_wdata  in  W_DATA  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  W_DATA  PRDATA for reads; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR, or timeout.
- timeout  out  1  one-cycle pulse when a transfer is aborted; constant 0 without the macro.
- apbm_psel, apbm_penable, apbm_pwrite  out  1  APB control.
- apbm_paddr  out  W_ADDR  APB address.
- apbm_pwdata  out  W_DATA  APB write data.
- apbm_prdata  in  W_DATA  APB read data.
- apbm_pready  in  1  APB ready.
- apbm_pslverr  in  1  APB error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state == IDLE). It is a registered state decode with no combinational path from cmd_valid.
- IDLE: on command handshake, capture cmd_write/addr/wdata into apbm_pwrite/paddr/pwdata, then go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS.
- ACCESS: psel=1, penable=1. On pready=1:
  - capture rdata (read) or 0 (write) into rsp_rdata;
  - capture pslverr into rsp_err;
  - drop psel/penable;
  - go to RESP.
- RESP: rsp_valid=1. On rsp_ready, go to IDLE. rsp_rdata/rsp_err hold until the handshake.
- paddr, pwdata and pwrite are stable from SETUP through the final ACCESS cycle. They retain their last values in IDLE and RESP.
- prdata and pslverr are sampled only in the ACCESS cycle with pready=1.
- pready is ignored outside ACCESS.
- Reset: all outputs go to 0 at the first rising edge with rst_n=0, and state goes to IDLE. cmd_ready is therefore 1 from the first cycle after reset releases.
- Reset mid-transfer: psel/penable drop at that edge and the transfer is discarded with no response.

## Timing
- Command handshake at edge N gives: SETUP in cycle N+1, ACCESS from N+2.
- With pready=1 in the first ACCESS cycle, rsp_valid rises in cycle N+3.
- Each pready=0 ACCESS cycle adds one cycle of latency.
- Minimum command-to-command spacing is 4 cycles: accept, SETUP, ACCESS, and RESP with rsp_ready=1.
- rsp_ready=0 stalls in RESP indefinitely. cmd_ready stays 0 during the stall.
- All outputs are registered.

## Configuration
- APB_CMD_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - If the counter reaches TIMEOUT_CYCLES with pready still 0, the FSM drops psel/penable, sets rsp_rdata=0 and rsp_err=1, pulses timeout for one cycle, and goes to RESP.
  - pready=1 in the same cycle as expiry wins, and the transfer completes normally.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter exists, ACCESS waits forever, and timeout is tied to 0.

## Structure
- Shared package apb_pkg holds:
  - state encodings (2 bits: IDLE=0, SETUP=1, ACCESS=2, RESP=3);
  - the default width constants, reusable by APB slaves.
- One sub-module: apb_cmd_master_timer, the timeout counter with clear, enable, expired. It is instantiated only under APB_CMD_MASTER_TIMEOUT_EN.

## Test plan
- Read, zero wait:
  - Stimulus: cmd addr=0x0004, read; slave pready=1 in the first ACCESS cycle, prdata=0xA5A5_0001.
  - Required: psel high 2 cycles, penable high 1; rsp_valid at N+3 with rdata=0xA5A5_0001, err=0.
- Write, 3 wait states:
  - Stimulus: addr=0x0000, wdata=0x0000_00FF; pready low for 3 ACCESS cycles.
  - Required: paddr/pwdata stable over 5 cycles of psel; rsp_rdata=0, err=0 at N+6.
- Slave error:
  - Stimulus: read with pslverr=1 alongside pready.
  - Required: rsp_err=1; next command accepted only after rsp_ready.
- Response backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles with cmd_valid=1.
  - Required: cmd_ready=0 throughout; response unchanged; accept 1 cycle after rsp_ready.
- Reset mid-ACCESS:
  - Stimulus: rst_n=0 for 1 cycle during a wait state.
  - Required: psel/penable/rsp_valid = 0 next cycle; no response; cmd_ready=1 after release.
- Timeout (macro on, TIMEOUT_CYCLES=4):
  - Stimulus: pready held 0.
  - Required: abort after 4 ACCESS cycles; timeout pulse; rsp_err=1, rdata=0.
  - Second run: pready=1 on the expiry cycle gives a normal completion with no timeout pulse.
